uart_regs_gen: RTL and testbench
================================

# uart_regs_gen

Parametrised UART register file and bus slave, the next-generation control/status front end between the data bus and the UART datapath/FIFOs. It adds configurable FIFO depth and baud-counter width, selectable character length and parity, write-1-to-clear sticky error status, and an optional error interrupt. All bus accesses complete in exactly one cycle; TX-FIFO push and RX-FIFO pop are single-cycle pulses.

## Interface
- FIFO_DEPTH, 8: TX/RX FIFO depth, power of two, 2..256; LVL_W = $clog2(FIFO_DEPTH)+1.
- BAUD_W, 16: baud divisor width, 8..24.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- uart_sel_i  in  1  address decode select.
- dbus2uart_i  in  type_dbus2peri_s  req, w_en, addr, w_data.
- uart2dbus_o  out  type_peri2dbus_s  ack, r_data.
- irq_o  out  1  OR of enabled pending interrupts.
- tx_fifo_full_i / rx_fifo_empty_i  in  1  FIFO flags.
- tx_fifo_level_i / rx_fifo_level_i  in  LVL_W  FIFO occupancy.
- rx_fifo_data_i  in  8  RX FIFO head.
- rx_push_i  in  1  datapath pushes a received character.
- rx_parity_err_i / rx_frame_err_i  in  1  single-cycle error pulses.
- tx_fifo_write_o / rx_fifo_read_o  out  1  push/pop pulses.
- tx_data_o  out  8  TX character.
- tx_en_o, rx_en_o, two_stop_bits_o  out  1  control.
- char_len_o  out  2  0=5..3=8 bits.
- parity_o  out  2  0 none, 1 even, 2 odd, 3 none.
- tx_watermark_o / rx_watermark_o  out  LVL_W-1.
- baud_rate_o  out  BAUD_W.

## Operation
- Access accepted when req & uart_sel_i & ~ack; index = addr[5:2].
- Registers: 0 TX_DATA W[7:0] push, R[31]=tx_fifo_full_i. 1 RX_DATA R{[31] empty, [7:0] data}. 2 TX_CTRL [0] en, [1] two stop, [3:2] char_len, [5:4] parity, [16+:LVL_W-1] watermark. 3 RX_CTRL [0] en, [16+:LVL_W-1] watermark. 4 INT_EN [2:0]. 5 INT_PEND R only. 6 BAUD [BAUD_W-1:0]. 7 STATUS [0] parity err, [1] frame err, [2] overrun, [3] tx drop; sticky, W1C. Others read 0, ignore writes.
- TX_DATA write with tx_fifo_full_i=1: no push, STATUS[3] set.
- RX_DATA read with FIFO empty: r_data=32'h8000_0000, no pop. Otherwise pop; r_data[7:0] = head sampled that edge.
- INT_PEND: [0] tx_fifo_level_i <= tx_watermark; [1] rx_fifo_level_i > rx_watermark (levels, not sticky); [2] |STATUS (macro only).
- Overrun: rx_push_i while level == FIFO_DEPTH and no pop that cycle.
- Error pulse coincident with W1C of same bit: set wins.
- Reserved write bits ignored, read 0.

## Timing
- Accept at edge N: ack and r_data valid cycle N+1 for one cycle; ack forces next cycle idle (held req → one access per two cycles).
- Write effect visible on outputs at N+1; tx_fifo_write_o/tx_data_o high at N+1 for one cycle.
- rx_fifo_read_o combinational in accept cycle N only.
- irq_o registered: reflects pending/enable one cycle after source changes.
- Reset: ack 0, r_data 0, irq_o 0, pulses 0, tx_data_o 8'h00, enables 0, char_len_o 3, parity_o 0, watermarks 0, baud_rate_o 16, STATUS 0, INT_EN 0. Reset mid-access aborts it: no ack.

## Configuration
- UART_ERR_IRQ_EN defined: INT_EN[2]/INT_PEND[2] implemented; STATUS errors raise irq_o.
- Undefined: bit 2 reads 0, write-ignored; STATUS still sticky and readable, never interrupts.

## Test plan
- Reset, read all 8 registers -> reset values above; BAUD=16, TX_CTRL=32'h0000_000C.
- Write TX_DATA 0x5A, not full -> ack at N+1, one tx_fifo_write_o pulse, tx_data_o=0x5A; repeat with full -> no pulse, STATUS=0x8, W1C 0x8 -> 0.
- RX FIFO holds 0x41,0x42; read RX_DATA three times -> 0x41, 0x42, 0x8000_0000; exactly two pops.
- rx_watermark=3, INT_EN=2, rx level 3→4 -> INT_PEND[1]=1, irq_o high next cycle; level 3 -> irq_o drops.
- With UART_ERR_IRQ_EN, INT_EN=4, rx_parity_err_i pulse coincident with W1C of bit0 -> STATUS[0]=1, irq_o=1; rebuild without macro -> irq_o stays 0.
- Held req for 4 cycles on BAUD write 0x1234 -> two acks, baud_rate_o=0x1234 after first.

Source files
------------

// File: rtl/uart_regs_gen.sv
// UART control/status register file and single-cycle data-bus slave.
// Define UART_ERR_IRQ_EN to let sticky STATUS errors raise irq_o through INT_EN[2].
package uart_regs_gen_pkg;

    typedef struct packed {
        logic        req;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] w_data;
    } type_dbus2peri_s;

    typedef struct packed {
        logic        ack;
        logic [31:0] r_data;
    } type_peri2dbus_s;

    typedef enum logic [3:0] {
        REG_TX_DATA  = 4'd0,
        REG_RX_DATA  = 4'd1,
        REG_TX_CTRL  = 4'd2,
        REG_RX_CTRL  = 4'd3,
        REG_INT_EN   = 4'd4,
        REG_INT_PEND = 4'd5,
        REG_BAUD     = 4'd6,
        REG_STATUS   = 4'd7
    } reg_idx_e;

endpackage

module uart_regs_gen
    import uart_regs_gen_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int BAUD_W     = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int WM_W       = LVL_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_sel_i,
    input  type_dbus2peri_s   dbus2uart_i,
    output type_peri2dbus_s   uart2dbus_o,
    output logic              irq_o,
    input  logic              tx_fifo_full_i,
    input  logic              rx_fifo_empty_i,
    input  logic [LVL_W-1:0]  tx_fifo_level_i,
    input  logic [LVL_W-1:0]  rx_fifo_level_i,
    input  logic [7:0]        rx_fifo_data_i,
    input  logic              rx_push_i,
    input  logic              rx_parity_err_i,
    input  logic              rx_frame_err_i,
    output logic              tx_fifo_write_o,
    output logic              rx_fifo_read_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_en_o,
    output logic              rx_en_o,
    output logic              two_stop_bits_o,
    output logic [1:0]        char_len_o,
    output logic [1:0]        parity_o,
    output logic [WM_W-1:0]   tx_watermark_o,
    output logic [WM_W-1:0]   rx_watermark_o,
    output logic [BAUD_W-1:0] baud_rate_o
);

`ifdef UART_ERR_IRQ_EN
    localparam logic [2:0] INT_EN_MASK = 3'b111;
`else
    localparam logic [2:0] INT_EN_MASK = 3'b011;
`endif

    logic        ack_q;
    logic [31:0] r_data_q;
    logic [2:0]  int_en_q;
    logic [3:0]  status_q;

    logic        accept;
    logic        wr;
    logic        rd;
    reg_idx_e    idx;
    logic        tx_push;
    logic        rx_pop;
    logic [2:0]  int_pend;
    logic [3:0]  status_set;
    logic [3:0]  status_clr;
    logic [31:0] rd_data;
    logic        unused_bus_bits;

    // The ack cycle is always idle, so a held request is served every other cycle.
    assign accept = dbus2uart_i.req & uart_sel_i & ~ack_q;
    assign wr     = accept & dbus2uart_i.w_en;
    assign rd     = accept & ~dbus2uart_i.w_en;
    assign idx    = reg_idx_e'(dbus2uart_i.addr[5:2]);

    assign tx_push        = wr & (idx == REG_TX_DATA) & ~tx_fifo_full_i;
    assign rx_pop         = rd & (idx == REG_RX_DATA) & ~rx_fifo_empty_i;
    assign rx_fifo_read_o = rx_pop;

    assign uart2dbus_o.ack    = ack_q;
    assign uart2dbus_o.r_data = r_data_q;

    assign unused_bus_bits = ^{dbus2uart_i.addr, dbus2uart_i.w_data};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        int_pend    = '0;
        int_pend[0] = tx_fifo_level_i <= {1'b0, tx_watermark_o};
        int_pend[1] = rx_fifo_level_i > {1'b0, rx_watermark_o};
`ifdef UART_ERR_IRQ_EN
        int_pend[2] = |status_q;
`endif
    end

    // A new error in the same cycle as its W1C wins over the clear.
    always_comb begin
        status_set    = '0;
        status_set[0] = rx_parity_err_i;
        status_set[1] = rx_frame_err_i;
        status_set[2] = rx_push_i & (rx_fifo_level_i == LVL_W'(FIFO_DEPTH)) & ~rx_pop;
        status_set[3] = wr & (idx == REG_TX_DATA) & tx_fifo_full_i;
        status_clr    = (wr && idx == REG_STATUS) ? dbus2uart_i.w_data[3:0] : '0;
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_TX_DATA:  rd_data[31] = tx_fifo_full_i;
            REG_RX_DATA:  rd_data = rx_fifo_empty_i ? 32'h8000_0000 : {24'h0, rx_fifo_data_i};
            REG_TX_CTRL: begin
                rd_data[0]           = tx_en_o;
                rd_data[1]           = two_stop_bits_o;
                rd_data[3:2]         = char_len_o;
                rd_data[5:4]         = parity_o;
                rd_data[16 +: WM_W]  = tx_watermark_o;
            end
            REG_RX_CTRL: begin
                rd_data[0]           = rx_en_o;
                rd_data[16 +: WM_W]  = rx_watermark_o;
            end
            REG_INT_EN:   rd_data[2:0] = int_en_q;
            REG_INT_PEND: rd_data[2:0] = int_pend;
            REG_BAUD:     rd_data[BAUD_W-1:0] = baud_rate_o;
            REG_STATUS:   rd_data[3:0] = status_q;
            default:      rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q           <= 1'b0;
            r_data_q        <= '0;
            irq_o           <= 1'b0;
            tx_fifo_write_o <= 1'b0;
            tx_data_o       <= 8'h00;
            tx_en_o         <= 1'b0;
            rx_en_o         <= 1'b0;
            two_stop_bits_o <= 1'b0;
            char_len_o      <= 2'd3;
            parity_o        <= 2'd0;
            tx_watermark_o  <= '0;
            rx_watermark_o  <= '0;
            baud_rate_o     <= BAUD_W'(16);
            int_en_q        <= '0;
            status_q        <= '0;
        end else begin
            ack_q           <= accept;
            r_data_q        <= rd ? rd_data : '0;
            tx_fifo_write_o <= tx_push;
            irq_o           <= |(int_pend & int_en_q);
            status_q        <= (status_q & ~status_clr) | status_set;
            if (tx_push) begin
                tx_data_o <= dbus2uart_i.w_data[7:0];
            end
            if (wr) begin
                case (idx)
                    REG_TX_CTRL: begin
                        tx_en_o         <= dbus2uart_i.w_data[0];
                        two_stop_bits_o <= dbus2uart_i.w_data[1];
                        char_len_o      <= dbus2uart_i.w_data[3:2];
                        parity_o        <= dbus2uart_i.w_data[5:4];
                        tx_watermark_o  <= dbus2uart_i.w_data[16 +: WM_W];
                    end
                    REG_RX_CTRL: begin
                        rx_en_o         <= dbus2uart_i.w_data[0];
                        rx_watermark_o  <= dbus2uart_i.w_data[16 +: WM_W];
                    end
                    REG_INT_EN:  int_en_q    <= dbus2uart_i.w_data[2:0] & INT_EN_MASK;
                    REG_BAUD:    baud_rate_o <= dbus2uart_i.w_data[BAUD_W-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_regs_gen.sv
// Randomised self-checking bench for uart_regs_gen against a register-image model.
// Honours UART_ERR_IRQ_EN in the model when the design is built with it.
module tb_uart_regs_gen;
    import uart_regs_gen_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int BAUD_W     = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int WM_W       = LVL_W - 1;
    localparam logic [31:0] WM_MASK   = (32'd1 << WM_W) - 32'd1;
    localparam logic [31:0] TXC_MASK  = 32'h3F | (WM_MASK << 16);
    localparam logic [31:0] RXC_MASK  = 32'h01 | (WM_MASK << 16);
    localparam logic [31:0] BAUD_MASK = (32'd1 << BAUD_W) - 32'd1;
`ifdef UART_ERR_IRQ_EN
    localparam logic [31:0] IEN_MASK  = 32'h7;
    localparam logic [31:0] ERR_IRQ   = 32'd1;
`else
    localparam logic [31:0] IEN_MASK  = 32'h3;
    localparam logic [31:0] ERR_IRQ   = 32'd0;
`endif

    logic              clk;
    logic              rst_n;
    logic              uart_sel_i;
    type_dbus2peri_s   bus;
    type_peri2dbus_s   resp;
    logic              irq_o;
    logic              tx_fifo_full_i;
    logic              rx_fifo_empty_i;
    logic [LVL_W-1:0]  tx_fifo_level_i;
    logic [LVL_W-1:0]  rx_fifo_level_i;
    logic [7:0]        rx_fifo_data_i;
    logic              rx_push_i;
    logic              rx_parity_err_i;
    logic              rx_frame_err_i;
    logic              tx_fifo_write_o;
    logic              rx_fifo_read_o;
    logic [7:0]        tx_data_o;
    logic              tx_en_o;
    logic              rx_en_o;
    logic              two_stop_bits_o;
    logic [1:0]        char_len_o;
    logic [1:0]        parity_o;
    logic [WM_W-1:0]   tx_watermark_o;
    logic [WM_W-1:0]   rx_watermark_o;
    logic [BAUD_W-1:0] baud_rate_o;

    uart_regs_gen #(.FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_sel_i      (uart_sel_i),
        .dbus2uart_i     (bus),
        .uart2dbus_o     (resp),
        .irq_o           (irq_o),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .tx_fifo_level_i (tx_fifo_level_i),
        .rx_fifo_level_i (rx_fifo_level_i),
        .rx_fifo_data_i  (rx_fifo_data_i),
        .rx_push_i       (rx_push_i),
        .rx_parity_err_i (rx_parity_err_i),
        .rx_frame_err_i  (rx_frame_err_i),
        .tx_fifo_write_o (tx_fifo_write_o),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .tx_data_o       (tx_data_o),
        .tx_en_o         (tx_en_o),
        .rx_en_o         (rx_en_o),
        .two_stop_bits_o (two_stop_bits_o),
        .char_len_o      (char_len_o),
        .parity_o        (parity_o),
        .tx_watermark_o  (tx_watermark_o),
        .rx_watermark_o  (rx_watermark_o),
        .baud_rate_o     (baud_rate_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Environment the bench presents to the DUT on the next cycle.
    logic             f_sel;
    logic             f_full;
    logic             f_empty;
    logic [LVL_W-1:0] f_tx_lvl;
    logic [LVL_W-1:0] f_rx_lvl;
    logic [7:0]       f_rx_data;

    // Model: register images as the bus sees them, plus expected registered outputs.
    logic [31:0] m_tx_ctrl, m_rx_ctrl, m_int_en, m_baud, m_status;
    logic [7:0]  m_tx_data;
    logic        m_ack, e_rdata_valid, e_tx_wr, e_irq;
    logic [31:0] e_rdata;

    logic [31:0] last_rdata;
    int          ack_cnt, tx_pulses, pops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tx_ctrl = 32'h0000_000C;
        m_rx_ctrl = '0;
        m_int_en  = '0;
        m_baud    = 32'd16;
        m_status  = '0;
        m_tx_data = 8'h00;
        m_ack     = 1'b0;
        e_rdata_valid = 1'b0;
        e_tx_wr   = 1'b0;
        e_irq     = 1'b0;
        e_rdata   = '0;
    endtask

    function automatic logic [31:0] pend();
        logic [31:0] p;
        p = '0;
        p[0] = 32'(f_tx_lvl) <= ((m_tx_ctrl >> 16) & WM_MASK);
        p[1] = 32'(f_rx_lvl) >  ((m_rx_ctrl >> 16) & WM_MASK);
        if (IEN_MASK[2]) p[2] = (m_status != 0);
        return p;
    endfunction

    function automatic logic [31:0] rd_val(input logic [3:0] idx);
        case (idx)
            4'd0: return f_full ? 32'h8000_0000 : 32'h0;
            4'd1: return f_empty ? 32'h8000_0000 : 32'(f_rx_data);
            4'd2: return m_tx_ctrl;
            4'd3: return m_rx_ctrl;
            4'd4: return m_int_en;
            4'd5: return pend();
            4'd6: return m_baud;
            4'd7: return m_status;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check combinational pop, predict, check after posedge.
    task automatic step(input logic req, input logic we, input logic [3:0] idx, input logic [31:0] wd,
                        input logic perr, input logic ferr, input logic push);
        logic [31:0] r, set, clr, p;
        logic        acc, pop;
        @(negedge clk);
        r = $urandom();
        uart_sel_i      = f_sel;
        bus.req         = req;
        bus.w_en        = we;
        bus.addr        = {r[31:6], idx, r[1:0]};
        bus.w_data      = wd;
        tx_fifo_full_i  = f_full;
        rx_fifo_empty_i = f_empty;
        tx_fifo_level_i = f_tx_lvl;
        rx_fifo_level_i = f_rx_lvl;
        rx_fifo_data_i  = f_rx_data;
        rx_parity_err_i = perr;
        rx_frame_err_i  = ferr;
        rx_push_i       = push;
        #1;
        acc = req & f_sel & ~m_ack;
        pop = acc & ~we & (idx == 4'd1) & ~f_empty;
        check("rx_pop", 32'(rx_fifo_read_o), 32'(pop));
        if (rx_fifo_read_o) pops++;

        p       = pend();
        e_irq   = |(p & m_int_en);
        e_rdata_valid = acc & ~we;
        e_rdata = rd_val(idx);
        e_tx_wr = acc & we & (idx == 4'd0) & ~f_full;
        set = '0;
        set[0] = perr;
        set[1] = ferr;
        set[2] = push & (32'(f_rx_lvl) == FIFO_DEPTH) & ~pop;
        set[3] = acc & we & (idx == 4'd0) & f_full;
        clr = (acc && we && idx == 4'd7) ? (wd & 32'hF) : 32'h0;
        if (acc && we) begin
            case (idx)
                4'd0: if (!f_full) m_tx_data = wd[7:0];
                4'd2: m_tx_ctrl = wd & TXC_MASK;
                4'd3: m_rx_ctrl = wd & RXC_MASK;
                4'd4: m_int_en  = wd & IEN_MASK;
                4'd6: m_baud    = wd & BAUD_MASK;
                default: ;
            endcase
        end
        m_status = (m_status & ~clr) | set;
        m_ack    = acc;

        @(posedge clk);
        #1;
        check("ack", 32'(resp.ack), 32'(m_ack));
        if (e_rdata_valid) check("r_data", resp.r_data, e_rdata);
        check("tx_write", 32'(tx_fifo_write_o), 32'(e_tx_wr));
        if (e_tx_wr) check("tx_data", 32'(tx_data_o), 32'(m_tx_data));
        check("irq", 32'(irq_o), 32'(e_irq));
        check("ctrl", 32'({tx_en_o, rx_en_o, two_stop_bits_o, char_len_o, parity_o}),
              32'({m_tx_ctrl[0], m_rx_ctrl[0], m_tx_ctrl[1], m_tx_ctrl[3:2], m_tx_ctrl[5:4]}));
        check("tx_wm", 32'(tx_watermark_o), (m_tx_ctrl >> 16) & WM_MASK);
        check("rx_wm", 32'(rx_watermark_o), (m_rx_ctrl >> 16) & WM_MASK);
        check("baud", 32'(baud_rate_o), m_baud);
        last_rdata = resp.r_data;
        if (resp.ack) ack_cnt++;
        if (tx_fifo_write_o) tx_pulses++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Single bus access followed by the mandatory idle cycle; returns the read data.
    task automatic access(input logic we, input logic [3:0] idx, input logic [31:0] wd,
                          output logic [31:0] rdata);
        step(1'b1, we, idx, wd, 1'b0, 1'b0, 1'b0);
        rdata = last_rdata;
        idle();
    endtask

    initial begin
        logic [31:0] rv;
        int          base;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        logic [31:0] rv;
        int          base;
        rst_n = 1'b1;
        uart_sel_i = 1'b0; bus = '0; tx_fifo_full_i = 1'b0; rx_fifo_empty_i = 1'b1;
        tx_fifo_level_i = '0; rx_fifo_level_i = '0; rx_fifo_data_i = 8'h00;
        rx_push_i = 1'b0; rx_parity_err_i = 1'b0; rx_frame_err_i = 1'b0;
        f_sel = 1'b1; f_full = 1'b0; f_empty = 1'b1; f_tx_lvl = '0; f_rx_lvl = '0; f_rx_data = 8'h00;
        ack_cnt = 0; tx_pulses = 0; pops = 0; last_rdata = '0;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check("rst_ack", 32'(resp.ack), 32'd0);
        check("rst_rdata", resp.r_data, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_txw", 32'(tx_fifo_write_o), 32'd0);
        check("rst_txdata", 32'(tx_data_o), 32'd0);
        check("rst_ctrl", 32'({tx_en_o, rx_en_o, two_stop_bits_o, char_len_o, parity_o}), 32'b0001100);
        check("rst_wm", 32'({tx_watermark_o, rx_watermark_o}), 32'd0);
        check("rst_baud", 32'(baud_rate_o), 32'd16);
        #19 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            access(1'b0, 4'(i), 32'h0, rv);
            if (i == 2) check("rst_tx_ctrl", rv, 32'h0000_000C);
            if (i == 6) check("rst_baud_reg", rv, 32'd16);
            if (i == 7) check("rst_status", rv, 32'd0);
        end

        base = tx_pulses;
        access(1'b1, 4'd0, 32'h0000_005A, rv);
        check("tx_push_cnt", 32'(tx_pulses - base), 32'd1);
        check("tx_data_5a", 32'(tx_data_o), 32'h5A);
        f_full = 1'b1;
        access(1'b1, 4'd0, 32'h0000_00A5, rv);
        check("tx_full_no_push", 32'(tx_pulses - base), 32'd1);
        f_full = 1'b0;
        access(1'b0, 4'd7, 32'h0, rv);
        check("tx_drop_status", rv, 32'h8);
        access(1'b1, 4'd7, 32'h8, rv);
        access(1'b0, 4'd7, 32'h0, rv);
        check("status_w1c", rv, 32'h0);

        base = pops;
        f_empty = 1'b0; f_rx_lvl = LVL_W'(2); f_rx_data = 8'h41;
        access(1'b0, 4'd1, 32'h0, rv);
        check("rx_first", rv, 32'h41);
        f_rx_lvl = LVL_W'(1); f_rx_data = 8'h42;
        access(1'b0, 4'd1, 32'h0, rv);
        check("rx_second", rv, 32'h42);
        f_empty = 1'b1; f_rx_lvl = '0; f_rx_data = 8'h99;
        access(1'b0, 4'd1, 32'h0, rv);
        check("rx_empty", rv, 32'h8000_0000);
        check("rx_pop_cnt", 32'(pops - base), 32'd2);

        access(1'b1, 4'd3, 32'h0003_0000, rv);
        access(1'b1, 4'd4, 32'h2, rv);
        f_empty = 1'b0; f_rx_lvl = LVL_W'(3);
        idle();
        check("wm_irq_low", 32'(irq_o), 32'd0);
        f_rx_lvl = LVL_W'(4);
        idle();
        check("wm_irq_high", 32'(irq_o), 32'd1);
        access(1'b0, 4'd5, 32'h0, rv);
        check("int_pend1", 32'(rv[1]), 32'd1);
        f_rx_lvl = LVL_W'(3);
        idle();
        check("wm_irq_drop", 32'(irq_o), 32'd0);

        access(1'b1, 4'd4, 32'h4, rv);
        step(1'b1, 1'b1, 4'd7, 32'h1, 1'b1, 1'b0, 1'b0);
        idle();
        access(1'b0, 4'd7, 32'h0, rv);
        check("err_set_wins", rv, 32'h1);
        check("err_irq", 32'(irq_o), ERR_IRQ);
        access(1'b1, 4'd7, 32'hF, rv);

        base = ack_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd6, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        check("held_req_acks", 32'(ack_cnt - base), 32'd2);
        check("held_req_baud", 32'(baud_rate_o), 32'h1234);
        idle();

        // Reset asserted while an access is being presented: no ack, registers back to reset values.
        @(negedge clk);
        uart_sel_i = 1'b1; bus.req = 1'b1; bus.w_en = 1'b1; bus.addr = 32'h18; bus.w_data = 32'h55;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ack", 32'(resp.ack), 32'd0);
        @(negedge clk);
        bus.req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("abort_ack2", 32'(resp.ack), 32'd0);
        check("abort_baud", 32'(baud_rate_o), 32'd16);

        for (int i = 0; i < 800; i++) begin
            logic [31:0] r;
            logic [3:0]  ridx;
            r = $urandom();
            f_sel     = (r[3:0] != 4'd0);
            f_full    = r[4];
            f_tx_lvl  = LVL_W'($urandom_range(0, FIFO_DEPTH));
            f_rx_lvl  = r[5] ? LVL_W'(FIFO_DEPTH) : LVL_W'($urandom_range(0, FIFO_DEPTH));
            f_empty   = (f_rx_lvl == '0);
            f_rx_data = 8'($urandom());
            ridx      = r[24] ? r[12:9] : {1'b0, r[11:9]};
            step(r[6] | r[7], r[8], ridx, $urandom(),
                 r[13] & r[14], r[15] & r[16], r[17] & r[18]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
